i2c_req_arbiter: RTL

I2C_REQ_ARBITER -- requirements
Module: i2c_req_arbiter

---
 rtl/i2c_arb_pkg.sv | 30 +++
 rtl/i2c_cond_detect.sv | 53 +++++
 rtl/i2c_req_arbiter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/i2c_arb_pkg.sv
// ============================================================================
// Module  : i2c_arb_pkg
// Brief   : State encoding, owner type and default timing for i2c_req_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package i2c_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LAUNCH     = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_WAIT_STOP  = 3'd3,
    ST_GAP        = 3'd4
  } arb_state_t;

  typedef logic owner_t;

  localparam int DEF_START_CYC   = 8;
  localparam int DEF_GAP_CYC     = 16;
  localparam int DEF_TIMEOUT_CYC = 65535;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_cond_detect.sv
// ============================================================================
// Module  : i2c_cond_detect
// Brief   : Two-flop SCL/SDA synchroniser with registered START/STOP pulses.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_cond_detect (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_sync_q, scl_sync_d;
  logic [1:0] sda_sync_q, sda_sync_d;
  logic       sda_prev_q, sda_prev_d;
  logic       start_det_q, start_det_d;
  logic       stop_det_q, stop_det_d;

  always_comb begin
    scl_sync_d  = {scl_sync_q[0], scl_in};
    sda_sync_d  = {sda_sync_q[0], sda_in};
    sda_prev_d  = sda_sync_q[1];
    // SDA transitions only count as bus conditions while SCL is high
    start_det_d = scl_sync_q[1] &  sda_prev_q & ~sda_sync_q[1];
    stop_det_d  = scl_sync_q[1] & ~sda_prev_q &  sda_sync_q[1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync_q  <= 2'b11;
      sda_sync_q  <= 2'b11;
      sda_prev_q  <= 1'b1;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
    end else begin
      scl_sync_q  <= scl_sync_d;
      sda_sync_q  <= sda_sync_d;
      sda_prev_q  <= sda_prev_d;
      start_det_q <= start_det_d;
      stop_det_q  <= stop_det_d;
    end
  end

  assign start_det = start_det_q;
  assign stop_det  = stop_det_q;

endmodule

`default_nettype wire

// File: rtl/i2c_req_arbiter.sv
// ============================================================================
// Module  : i2c_req_arbiter
// Brief   : Round-robin arbiter sharing one I2C master between two requesters.
//           Define I2C_ARB_TIMEOUT_EN to add the WAIT_START/WAIT_STOP timeout.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_req_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int START_CYC   = DEF_START_CYC,
  parameter int GAP_CYC     = DEF_GAP_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [6:0] addr0,
  input  logic [6:0] addr1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic       rw0,
  input  logic       rw1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic       err,
  output logic       start,
  output logic [6:0] addr,
  output logic [7:0] data,
  output logic       rw,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       busy
);

  localparam int CW = cnt_width((START_CYC > GAP_CYC) ? START_CYC : GAP_CYC);

  arb_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  owner_t     owner_q, owner_d;
  owner_t     sel;
  logic [6:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       rw_q, rw_d;
  logic       start_q, start_d;
  logic       gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic       done0_q, done0_d, done1_q, done1_d;
  logic       finish;
  logic       start_det, stop_det;

  i2c_cond_detect u_cond_detect (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int TW = cnt_width(TIMEOUT_CYC);
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          err_q, err_d;
  logic          timeout_hit;

  assign timeout_hit = (tcnt_q == TW'(TIMEOUT_CYC));

  always_comb begin
    tcnt_d = '0;
    if (state_q == ST_WAIT_START || state_q == ST_WAIT_STOP) tcnt_d = tcnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rw_d    = rw_q;
    start_d = (state_q == ST_LAUNCH);
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    finish  = 1'b0;
    sel     = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          // on a tie the requester that was not served last wins
          sel     = (req0 && req1) ? ~owner_q : req1;
          owner_d = sel;
          gnt0_d  = ~sel;
          gnt1_d  = sel;
          addr_d  = sel ? addr1 : addr0;
          data_d  = sel ? data1 : data0;
          rw_d    = sel ? rw1 : rw0;
          cnt_d   = '0;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        if (cnt_q == CW'(START_CYC - 1)) begin
          cnt_d   = '0;
          state_d = ST_WAIT_START;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_START: begin
        if (start_det) state_d = ST_WAIT_STOP;
`ifdef I2C_ARB_TIMEOUT_EN
        else if (timeout_hit) begin
          finish = 1'b1;
          err_d  = 1'b1;
        end
`endif
      end
      ST_WAIT_STOP: begin
        if (stop_det) finish = 1'b1;
`ifdef I2C_ARB_TIMEOUT_EN
        else if (timeout_hit) begin
          finish = 1'b1;
          err_d  = 1'b1;
        end
`endif
      end
      ST_GAP: begin
        if (start_det) cnt_d = '0;
        else if (cnt_q == CW'(GAP_CYC - 1)) state_d = ST_IDLE;
        else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (finish) begin
      done0_d = ~owner_q;
      done1_d = owner_q;
      cnt_d   = '0;
      state_d = ST_GAP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      owner_q <= 1'b1;
      addr_q  <= '0;
      data_q  <= '0;
      rw_q    <= 1'b0;
      start_q <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rw_q    <= rw_d;
      start_q <= start_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
    end
  end

  assign gnt0  = gnt0_q;
  assign gnt1  = gnt1_q;
  assign done0 = done0_q;
  assign done1 = done1_q;
  assign start = start_q;
  assign addr  = addr_q;
  assign data  = data_q;
  assign rw    = rw_q;
  assign busy  = (state_q != ST_IDLE);

endmodule

`default_nettype wire
